// File: rtl/bitfield_mask.sv
// Two-stage mask generator / field extractor with valid/ready on both sides.
// Stage 1 builds the mask and field width; stage 2 selects the result and its popcount.
module bitfield_mask #(
  parameter int W  = 16,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    mode,
  input  logic [CW-1:0] lo,
  input  logic [CW-1:0] hi,
  input  logic          inv,
  input  logic [W-1:0]  din,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  dout,
  output logic [CW:0]   ones
);

  localparam logic [1:0] MODE_SEL     = 2'b00;
  localparam logic [1:0] MODE_LOW     = 2'b01;
  localparam logic [1:0] MODE_RANGE   = 2'b10;
  localparam logic [1:0] MODE_EXTRACT = 2'b11;

  logic          s1_valid;
  logic [W-1:0]  s1_m;
  logic [W-1:0]  s1_din;
  logic [1:0]    s1_mode;
  logic [CW-1:0] s1_lo;
  logic [CW:0]   s1_fw;
  logic          s2_valid;

  logic          s2_can_load;
  logic          s1_advance;
  logic [W-1:0]  gen_m;
  logic [CW:0]   fw_c;
  logic [W-1:0]  field_mask;
  logic [W-1:0]  res_c;
  logic [CW:0]   ones_c;

  assign s2_can_load = out_ready | ~s2_valid;
  assign s1_advance  = s1_valid & s2_can_load;
  assign in_ready    = ~s1_valid | s2_can_load;
  assign out_valid   = s2_valid;

  always_comb begin
    gen_m = '0;
    for (int i = 0; i < W; i++) begin
      case (mode)
        MODE_SEL: gen_m[i] = (i == int'(lo));
        MODE_LOW: gen_m[i] = (i < int'(lo));
        default:  gen_m[i] = (i >= int'(lo)) && (i <= int'(hi));
      endcase
    end
    if (inv && (mode != MODE_EXTRACT)) gen_m = ~gen_m;
  end

  // An inverted range (lo > hi) is an empty field, never a wrap-around.
  assign fw_c = (hi >= lo) ? ({1'b0, hi} - {1'b0, lo} + {{CW{1'b0}}, 1'b1}) : '0;

  always_comb begin
    field_mask = '0;
    for (int i = 0; i < W; i++) field_mask[i] = (i < int'(s1_fw));
  end

  assign res_c = (s1_mode == MODE_EXTRACT) ? ((s1_din >> s1_lo) & field_mask) : s1_m;

  always_comb begin
    ones_c = '0;
    for (int i = 0; i < W; i++) ones_c = ones_c + {{CW{1'b0}}, res_c[i]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_m     <= '0;
      s1_din   <= '0;
      s1_mode  <= MODE_SEL;
      s1_lo    <= '0;
      s1_fw    <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_m    <= gen_m;
        s1_din  <= din;
        s1_mode <= mode;
        s1_lo   <= lo;
        s1_fw   <= fw_c;
      end
    end
  end

  // dout/ones only move when stage 2 is free to load, so a stalled beat holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      dout     <= '0;
      ones     <= '0;
    end else if (s2_can_load) begin
      s2_valid <= s1_valid;
      if (s1_advance) begin
        dout <= res_c;
        ones <= ones_c;
      end
    end
  end

endmodule

// File: tb/tb_bitfield_mask.sv
// Self-checking bench for bitfield_mask (W=16): directed vectors, backpressure,
// mid-operation reset and a randomized scoreboard run against an arithmetic model.
module tb_bitfield_mask;

  localparam int W  = 16;
  localparam int CW = 4;

  typedef struct packed {
    logic [1:0]  md;
    logic [3:0]  l;
    logic [3:0]  h;
    logic        iv;
    logic [15:0] d;
  } req_t;

  typedef struct {
    req_t        r;
    logic [15:0] ed;
    logic [4:0]  eo;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    mode = '0;
  logic [CW-1:0] lo = '0;
  logic [CW-1:0] hi = '0;
  logic          inv = 1'b0;
  logic [W-1:0]  din = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  dout;
  logic [CW:0]   ones;

  int n_pass = 0;
  int n_total = 0;

  bitfield_mask #(.W(W), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .lo(lo), .hi(hi), .inv(inv), .din(din),
    .out_valid(out_valid), .out_ready(out_ready), .dout(dout), .ones(ones)
  );

  always #5 clk = ~clk;

  // Reference: masks built from shifted ones in plain integer arithmetic.
  function automatic logic [15:0] model(input req_t r);
    int l, h, m, dv;
    l = int'(r.l);
    h = int'(r.h);
    dv = int'(r.d);
    case (r.md)
      2'd0: m = 1 << l;
      2'd1: m = (1 << l) - 1;
      2'd2: m = (l > h) ? 0 : ((1 << (h + 1)) - 1) - ((1 << l) - 1);
      default: return (l > h) ? 16'h0 : 16'((dv >> l) & ((1 << (h - l + 1)) - 1));
    endcase
    if (r.iv) m = ~m;
    return 16'(m);
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r.md = 2'($urandom_range(0, 3));
    r.l  = 4'($urandom_range(0, 15));
    r.h  = 4'($urandom_range(0, 15));
    r.iv = 1'($urandom_range(0, 1));
    r.d  = 16'($urandom);
    return r;
  endfunction

  task automatic drive(input req_t r, input logic v);
    in_valid = v;
    mode = r.md;
    lo = r.l;
    hi = r.h;
    inv = r.iv;
    din = r.d;
  endtask

  task automatic test_reset();
    #2;
    n_total++;
    if (out_valid !== 1'b0 || dout !== 16'h0 || ones !== 5'd0 || in_ready !== 1'b1)
      $display("FAIL reset_state: out_valid=%b dout=%h ones=%0d in_ready=%b, want 0 0000 0 1",
               out_valid, dout, ones, in_ready);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_modes();
    vec_t v[11];
    v[0]  = '{'{2'd0, 4'd5,  4'd0,  1'b0, 16'h0},    16'h0020, 5'd1};
    v[1]  = '{'{2'd0, 4'd5,  4'd0,  1'b1, 16'h0},    16'hFFDF, 5'd15};
    v[2]  = '{'{2'd1, 4'd0,  4'd0,  1'b0, 16'h0},    16'h0000, 5'd0};
    v[3]  = '{'{2'd1, 4'd15, 4'd0,  1'b0, 16'h0},    16'h7FFF, 5'd15};
    v[4]  = '{'{2'd2, 4'd4,  4'd11, 1'b0, 16'h0},    16'h0FF0, 5'd8};
    v[5]  = '{'{2'd2, 4'd9,  4'd3,  1'b0, 16'h0},    16'h0000, 5'd0};
    v[6]  = '{'{2'd2, 4'd9,  4'd3,  1'b1, 16'h0},    16'hFFFF, 5'd16};
    v[7]  = '{'{2'd3, 4'd4,  4'd11, 1'b0, 16'hABCD}, 16'h00BC, 5'd5};
    v[8]  = '{'{2'd3, 4'd0,  4'd15, 1'b0, 16'hABCD}, 16'hABCD, 5'd10};
    v[9]  = '{'{2'd3, 4'd15, 4'd15, 1'b0, 16'hABCD}, 16'h0001, 5'd1};
    v[10] = '{'{2'd3, 4'd4,  4'd11, 1'b1, 16'hABCD}, 16'h00BC, 5'd5};
    out_ready = 1'b1;
    for (int k = 0; k < 11; k++) begin
      drive(v[k].r, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      n_total++;
      if (out_valid !== 1'b0) $display("FAIL mode_early[%0d]: out_valid=%b want 0", k, out_valid);
      else n_pass++;
      @(posedge clk); #1;
      @(negedge clk);
      n_total++;
      if (out_valid !== 1'b1 || dout !== v[k].ed || ones !== v[k].eo)
        $display("FAIL mode_result[%0d]: valid=%b dout=%h ones=%0d, want 1 %h %0d",
                 k, out_valid, dout, ones, v[k].ed, v[k].eo);
      else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    req_t        reqs[8];
    logic [15:0] exp_d[8];
    int k = 0, r = 0, cyc = 0;
    logic rdy, ov;
    for (int i = 0; i < 8; i++) begin
      reqs[i] = rand_req();
      exp_d[i] = model(reqs[i]);
    end
    out_ready = 1'b0;
    for (int c = 0; c < 12; c++) begin
      drive(reqs[k], 1'b1);
      @(negedge clk);
      rdy = in_ready;
      if (c >= 2) begin
        n_total++;
        if (rdy !== 1'b0 || out_valid !== 1'b1 || dout !== exp_d[0] || ones !== 5'($countones(exp_d[0])))
          $display("FAIL bp_stall[c%0d]: in_ready=%b out_valid=%b dout=%h ones=%0d, want 0 1 %h %0d",
                   c, rdy, out_valid, dout, ones, exp_d[0], $countones(exp_d[0]));
        else n_pass++;
      end
      @(posedge clk); #1;
      if (rdy) k++;
    end
    n_total++;
    if (k !== 2) $display("FAIL bp_accepts: accepted=%0d want 2", k);
    else n_pass++;
    while (r < 8 && cyc < 300) begin
      drive(reqs[(k < 8) ? k : 0], k < 8);
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      rdy = in_ready;
      ov = out_valid;
      if (ov && out_ready) begin
        n_total++;
        if (dout !== exp_d[r] || ones !== 5'($countones(exp_d[r])))
          $display("FAIL bp_order[%0d]: dout=%h ones=%0d, want %h %0d",
                   r, dout, ones, exp_d[r], $countones(exp_d[r]));
        else n_pass++;
      end
      @(posedge clk); #1;
      if (in_valid && rdy) k++;
      if (ov && out_ready) r++;
      cyc++;
    end
    n_total++;
    if (r !== 8 || k !== 8) $display("FAIL bp_drain: received=%0d accepted=%0d, want 8 8", r, k);
    else n_pass++;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL bp_no_dup: out_valid=%b want 0", out_valid);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midop();
    req_t r;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(rand_req(), 1'b1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    n_total++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0)
      $display("FAIL rst_full: out_valid=%b in_ready=%b, want 1 0", out_valid, in_ready);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (out_valid !== 1'b0 || dout !== 16'h0 || ones !== 5'd0)
      $display("FAIL rst_async: out_valid=%b dout=%h ones=%0d, want 0 0000 0", out_valid, dout, ones);
    else n_pass++;
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    r = '{2'd0, 4'd3, 4'd0, 1'b0, 16'h0};
    out_ready = 1'b1;
    drive(r, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL rst_relat_early: out_valid=%b want 0", out_valid);
    else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_total++;
    if (out_valid !== 1'b1 || dout !== 16'h0008 || ones !== 5'd1)
      $display("FAIL rst_relat: valid=%b dout=%h ones=%0d, want 1 0008 1", out_valid, dout, ones);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [15:0] exp_q[$];
    logic [15:0] e, d, prev_d;
    logic [4:0]  o;
    logic rdy, ov, prev_stall;
    req_t cur;
    int sent = 0, got = 0, cyc = 0;
    prev_stall = 1'b0;
    prev_d = '0;
    while (got < 10000 && cyc < 80000) begin
      cur = rand_req();
      drive(cur, (sent < 10000) && ($urandom_range(0, 99) < 70));
      out_ready = ($urandom_range(0, 99) < 70);
      @(negedge clk);
      rdy = in_ready;
      ov = out_valid;
      d = dout;
      o = ones;
      if (prev_stall) begin
        n_total++;
        if (!ov || d !== prev_d) $display("FAIL rand_hold: valid=%b dout=%h, want 1 %h", ov, d, prev_d);
        else n_pass++;
      end
      if (ov) begin
        n_total++;
        if (o !== 5'($countones(d))) $display("FAIL rand_ones: ones=%0d dout=%h want %0d", o, d, $countones(d));
        else n_pass++;
      end
      if (ov && out_ready) begin
        n_total++;
        if (exp_q.size() == 0) $display("FAIL rand_extra: unexpected dout=%h", d);
        else begin
          e = exp_q.pop_front();
          if (d !== e) $display("FAIL rand_data[%0d]: dout=%h want %h", got, d, e);
          else n_pass++;
        end
      end
      prev_stall = ov && !out_ready;
      prev_d = d;
      @(posedge clk); #1;
      if (in_valid && rdy) begin
        exp_q.push_back(model(cur));
        sent++;
      end
      if (ov && out_ready) got++;
      cyc++;
    end
    in_valid = 1'b0;
    n_total++;
    if (got !== 10000) $display("FAIL rand_count: received=%0d want 10000", got);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_modes();
    test_back_to_back();
    test_reset_midop();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bitfield_mask.md
Name: bitfield_mask

Overview:
- Parametrised, pipelined bit-mask generator and field extractor for the DSP and control datapaths.
- Generates W-bit masks in four modes: single-bit select, low-bit mask, inclusive range, and field extract from a data word.
- Also returns the population count of the generated mask.
- Two-stage pipeline with valid/ready flow control on both sides; sits between the control-register decode and the packing/unpacking logic.

Parameters:
- W, 16, data and mask width in bits; must be a power of two, 4 to 64.
- CW, 4, index width; must equal log2(W).

Ports:
- clk  input  1  system clock; all state is updated on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted this cycle when in_valid and in_ready are both 1.
- mode  input  2  00 SEL, 01 LOW, 10 RANGE, 11 EXTRACT.
- lo  input  CW  bit index (SEL/LOW), or low index of the field (RANGE/EXTRACT).
- hi  input  CW  high index of the field, inclusive (RANGE/EXTRACT); ignored for SEL/LOW.
- inv  input  1  invert the generated mask before use; ignored in EXTRACT.
- din  input  W  data word; used only in EXTRACT.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- dout  output  W  mask (SEL/LOW/RANGE), or right-justified field (EXTRACT).
- ones  output  CW+1  number of 1 bits in dout.

Behaviour:
- Reset (async assert, sync deassert handled externally):
  - s1_valid, s2_valid, out_valid = 0.
  - dout = 0, ones = 0.
  - All internal mask and data registers = 0.
- Mask generation, bit i of m:
  - SEL: m[i] = (i == lo).
  - LOW: m[i] = (i < lo), so lo = 0 gives all zeros and at most W-1 bits are set.
  - RANGE: m[i] = (lo <= i <= hi); if lo > hi then m = 0 (no wrap-around).
  - Modes SEL/LOW/RANGE: if inv = 1, m is replaced by ~m.
- Stage 1 (on accept):
  - Registers m (W bits), din, mode, lo, and fw = hi - lo + 1 (CW+1 bits, unsigned).
  - For EXTRACT with lo > hi, fw = 0.
  - Sets s1_valid.
- Stage 2:
  - SEL/LOW/RANGE: dout = m.
  - EXTRACT: dout = (din >> lo) & ((1 << fw) - 1). fw = W yields all ones; fw = 0 yields 0.
  - ones = popcount(dout), computed combinationally from the stage-2 result and registered together with dout.
  - out_valid = s2_valid.
- Latency: result appears exactly 2 cycles after acceptance when there is no backpressure. Throughput is 1 per cycle.
- Flow control:
  - s2 advance when out_ready = 1 or s2_valid = 0.
  - s1 advance when s2 can load or s1_valid = 0.
  - in_ready = ~s1_valid | s2_can_load, computed combinationally from registered state and out_ready. in_ready has no path from in_valid.
  - With out_ready = 0 the pipeline fills: after 2 accepts, in_ready drops and dout/ones/out_valid hold stable.
  - On the cycle out_ready returns to 1, both stages shift; in_ready is 1 in that same cycle.
- Ordering: results leave strictly in acceptance order. No request is lost or duplicated under any valid/ready pattern.
- While out_valid = 1 and out_ready = 0, dout and ones must not change.
- Reset asserted mid-operation discards both stages immediately; out_valid falls asynchronously.
- Undefined mode encodings: none; all 4 encodings are defined.
- Inputs other than in_valid are don't-care when in_valid = 0.

Test Plan:
1. W=16, no backpressure, SEL lo=5 inv=0 -> 2 cycles later dout=0x0020, ones=1; same with inv=1 -> dout=0xFFDF, ones=15.
2. LOW lo=0 -> dout=0x0000, ones=0; LOW lo=15 -> dout=0x7FFF, ones=15; RANGE lo=4 hi=11 -> dout=0x0FF0, ones=8; RANGE lo=9 hi=3 -> dout=0x0000, ones=0.
3. EXTRACT din=0xABCD lo=4 hi=11 -> dout=0x00BC, ones=5; lo=0 hi=15 -> dout=0xABCD, ones=10; lo=15 hi=15 -> dout=0x0001, ones=1.
4. Back-to-back 8 requests with out_ready held 0 -> exactly 2 accepted, in_ready=0 thereafter, dout stable. Then random out_ready -> all 8 results in order, none dropped.
5. Assert rst_n=0 with both stages full -> out_valid=0 and dout=0 without a clock edge; after release, first new request appears with 2-cycle latency.
6. Random mode/lo/hi/inv/din for 10k requests, random valid/ready -> scoreboard match against a reference model, ones == popcount(dout) every beat.
